// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_e;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    function automatic logic src_hazard(
        input logic                  uses_src,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd
    );
        return uses_src && (rd != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-high clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline with memory
// handshake, timeout halt and saturating performance counters
module hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  exmem_branch,
    input  logic                  exmem_zero,
    input  logic                  exmem_mem_read,
    input  logic                  exmem_mem_write,
    input  logic                  dmem_ready,
    output logic                  dmem_req,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  mem_wb_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic                  mem_error,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    ctrl_state_e state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;

    logic       mem_op;
    logic       taken;
    logic       load_use;
    logic       freeze;
    logic       branch_flush;
    logic [7:0] wait_inc;

    assign mem_op   = exmem_mem_read | exmem_mem_write;
    assign taken    = exmem_branch & exmem_zero;
    assign load_use = idex_mem_read &
                      (src_hazard(id_uses_rs1, id_rs1, idex_rd) |
                       src_hazard(id_uses_rs2, id_rs2, idex_rd));
    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        err_d        = err_q;
        freeze       = 1'b0;
        branch_flush = 1'b0;
        dmem_req     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state_q != HALT) begin
            dmem_req = mem_op;
            // EX/MEM is frozen while waiting, so the pending access is implied in MEM_WAIT.
            freeze   = (state_q == MEM_WAIT) ? !dmem_ready : (mem_op & !dmem_ready);

            if (freeze) begin
                mem_wb_write = 1'b1;
                mem_wb_flush = 1'b1;
                if (state_q == RUN) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd0;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == TIMEOUT_C) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end
                end
            end else begin
                state_d      = RUN;
                wait_d       = 8'd0;
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
                mem_wb_write = 1'b1;
                if (taken) begin
                    branch_flush = 1'b1;
                    pc_src       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign mem_error = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!reset && !pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (!reset && branch_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CW = 4;

    // {dmem_req, pc_write, pc_src, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_f, id_ex_f, ex_mem_f, mem_wb_f}
    localparam logic [10:0] E_NORM   = 11'b0_1_0_1111_0000;
    localparam logic [10:0] E_NORMM  = 11'b1_1_0_1111_0000;
    localparam logic [10:0] E_LU     = 11'b0_0_0_0111_0100;
    localparam logic [10:0] E_BR     = 11'b0_1_1_1111_1110;
    localparam logic [10:0] E_BRM    = 11'b1_1_1_1111_1110;
    localparam logic [10:0] E_FRZ    = 11'b1_0_0_0001_0001;
    localparam logic [10:0] E_HALT   = 11'b0_0_0_0000_0000;
    localparam logic [10:0] E_RST    = 11'b0_0_0_0000_1111;

    typedef struct {
        string       tag;
        logic [10:0] ctrl;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, idex_rd;
    logic          id_uses_rs1, id_uses_rs2, idex_mem_read;
    logic          exmem_branch, exmem_zero, exmem_mem_read, exmem_mem_write, dmem_ready;
    logic          dmem_req, pc_write, pc_src;
    logic          if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic          mem_error;
    logic [CW-1:0] stall_cycles, flush_count;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .idex_mem_read   (idex_mem_read),
        .idex_rd         (idex_rd),
        .exmem_branch    (exmem_branch),
        .exmem_zero      (exmem_zero),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_mem_write (exmem_mem_write),
        .dmem_ready      (dmem_ready),
        .dmem_req        (dmem_req),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .if_id_write     (if_id_write),
        .id_ex_write     (id_ex_write),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_write    (mem_wb_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mem_error       (mem_error),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    wire [10:0] ctrl_obs = {dmem_req, pc_write, pc_src, if_id_write, id_ex_write, ex_mem_write,
                            mem_wb_write, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic step(input string tag, input logic [10:0] exp_ctrl);
        exp_t e;
        exp_t got;
        e.tag  = tag;
        e.ctrl = exp_ctrl;
        sb_q.push_back(e);
        @(negedge clock);
        got = sb_q.pop_front();
        n_cmp++;
        assert (ctrl_obs === got.ctrl) else begin
            n_err++;
            $error("FAIL %s: observed ctrl=%b expected ctrl=%b", got.tag, ctrl_obs, got.ctrl);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
        exmem_branch = 1'b0; exmem_zero = 1'b0;
        exmem_mem_read = 1'b0; exmem_mem_write = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        step("reset_outputs", E_RST);
        chk("reset_stall", 8'(stall_cycles), 8'd0);
        chk("reset_flush", 8'(flush_count), 8'd0);
        chk("reset_err", 8'(mem_error), 8'd0);

        reset = 1'b0;
        step("idle", E_NORM);
        chk("idle_stall", 8'(stall_cycles), 8'd0);

        idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        step("load_use_rs1", E_LU);
        chk("lu_stall", 8'(stall_cycles), 8'd1);
        idex_mem_read = 1'b0;
        step("after_lu", E_NORM);
        chk("after_lu_stall", 8'(stall_cycles), 8'd1);

        idex_mem_read = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0;
        step("x0_exempt", E_NORM);
        idex_rd = 5'd6; id_rs1 = 5'd5;
        step("rd_mismatch", E_NORM);
        id_rs2 = 5'd6; id_uses_rs2 = 1'b1;
        step("load_use_rs2", E_LU);
        chk("lu2_stall", 8'(stall_cycles), 8'd2);
        id_uses_rs2 = 1'b0;
        step("rs2_unused", E_NORM);

        id_uses_rs2 = 1'b1; exmem_branch = 1'b1; exmem_zero = 1'b1;
        step("branch_over_lu", E_BR);
        chk("br_flush", 8'(flush_count), 8'd1);
        chk("br_stall", 8'(stall_cycles), 8'd2);
        idle_inputs();
        exmem_branch = 1'b1;
        step("branch_not_taken", E_NORM);
        chk("bnt_flush", 8'(flush_count), 8'd1);

        idle_inputs();
        exmem_mem_read = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_freeze", E_FRZ);
        dmem_ready = 1'b1;
        step("mem_ready", E_NORMM);
        chk("mem_wait_stall", 8'(stall_cycles), 8'd5);
        exmem_mem_read = 1'b0; dmem_ready = 1'b0;
        step("back_in_run", E_NORM);
        exmem_mem_write = 1'b1; dmem_ready = 1'b1;
        step("zero_wait", E_NORMM);
        chk("zero_wait_stall", 8'(stall_cycles), 8'd5);

        exmem_mem_write = 1'b0; exmem_mem_read = 1'b1; dmem_ready = 1'b0;
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        step("freeze_over_branch", E_FRZ);
        chk("fob_flush", 8'(flush_count), 8'd1);
        dmem_ready = 1'b1;
        step("branch_on_ready", E_BRM);
        chk("bor_flush", 8'(flush_count), 8'd2);
        chk("bor_stall", 8'(stall_cycles), 8'd6);

        idle_inputs();
        exmem_mem_read = 1'b1;
        step("to_freeze", E_FRZ);
        for (int i = 0; i < 3; i++) step("wait_pre_timeout", E_FRZ);
        chk("err_before_timeout", 8'(mem_error), 8'd0);
        step("wait_timeout", E_FRZ);
        chk("err_at_timeout", 8'(mem_error), 8'd1);
        chk("timeout_stall", 8'(stall_cycles), 8'd11);
        for (int i = 0; i < 3; i++) step("halt", E_HALT);
        chk("halt_stall", 8'(stall_cycles), 8'd14);
        dmem_ready = 1'b1;
        step("halt_ignores_ready", E_HALT);
        step("halt_sat", E_HALT);
        step("halt_sat2", E_HALT);
        chk("halt_sat_stall", 8'(stall_cycles), 8'd15);
        chk("halt_err_sticky", 8'(mem_error), 8'd1);

        reset = 1'b1;
        step("reset_from_halt", E_RST);
        chk("rst_halt_err", 8'(mem_error), 8'd0);
        chk("rst_halt_stall", 8'(stall_cycles), 8'd0);
        chk("rst_halt_flush", 8'(flush_count), 8'd0);
        reset = 1'b0;
        step("run_after_reset", E_NORMM);

        dmem_ready = 1'b0;
        step("mw_a", E_FRZ);
        step("mw_b", E_FRZ);
        reset = 1'b1;
        step("reset_mid_wait", E_RST);
        reset = 1'b0;
        step("mw_restart", E_FRZ);
        for (int i = 0; i < 3; i++) step("mw_count", E_FRZ);
        chk("mw_err_pre", 8'(mem_error), 8'd0);
        step("mw_timeout", E_FRZ);
        chk("mw_err", 8'(mem_error), 8'd1);
        step("mw_halt", E_HALT);

        reset = 1'b1;
        idle_inputs();
        step("reset_for_sat", E_RST);
        reset = 1'b0;
        idex_mem_read = 1'b1; idex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        for (int i = 0; i < 20; i++) step("sat_lu", E_LU);
        chk("sat_stall", 8'(stall_cycles), 8'd15);
        idex_mem_read = 1'b0;
        step("sat_normal", E_NORM);
        chk("sat_hold", 8'(stall_cycles), 8'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage 32-bit RISC-V core. It drives the write-enable and flush controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects three conditions:
- load-use data hazards,
- taken branches resolved in MEM,
- multi-cycle data-memory accesses, handled with a request/ready handshake.

A 3-state FSM adds a memory timeout with a sticky error halt. Saturating performance counters record stall and flush activity.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before halting. Range 1..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clock, in, 1: single clock. All state updates on posedge.
- reset, in, 1: synchronous, active-high.
- id_rs1, id_rs2, in, 5 each: source registers of the instruction in IF/ID.
- id_uses_rs1, id_uses_rs2, in, 1 each: the source operand is actually read.
- idex_mem_read, in, 1: ID/EX holds a load.
- idex_rd, in, 5: destination register of ID/EX.
- exmem_branch, exmem_zero, in, 1 each: EX/MEM branch flag and ALU zero flag.
- exmem_mem_read, exmem_mem_write, in, 1 each: EX/MEM holds a memory operation.
- dmem_ready, in, 1: data memory completes the access this cycle.
- dmem_req, out, 1: data-memory access request.
- pc_write, out, 1: PC update enable.
- pc_src, out, 1: PC takes the EX/MEM branch target.
- if_id_write, id_ex_write, ex_mem_write, mem_wb_write, out, 1 each: register enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, out, 1 each: load a bubble (all zeros) on the next edge. A flush takes effect even if the same register's write enable is 0.
- mem_error, out, 1: sticky timeout flag.
- stall_cycles, out, CNT_W: count of cycles with pc_write=0.
- flush_count, out, CNT_W: count of taken-branch flushes.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. The reset state is RUN.
- Derived terms:
  - mem_op = exmem_mem_read | exmem_mem_write.
  - taken = exmem_branch & exmem_zero.
  - load_use = idex_mem_read & (idex_rd != 0) & ((id_uses_rs1 & id_rs1 == idex_rd) | (id_uses_rs2 & id_rs2 == idex_rd)).
- dmem_req = mem_op while in RUN or MEM_WAIT. It is 0 in HALT.
- Priority in RUN / MEM_WAIT: memory freeze, then branch flush, then load-use, then normal.
  - **Freeze** (mem_op & !dmem_ready):
    - pc_write and if_id_write, id_ex_write, ex_mem_write are all 0.
    - mem_wb_flush=1, so MEM/WB receives a bubble.
    - Next state is MEM_WAIT.
  - **Branch** (taken, no freeze):
    - pc_src=1, pc_write=1.
    - if_id_flush, id_ex_flush, ex_mem_flush are all 1.
    - No load-use stall is applied.
  - **Load-use** (no freeze, no taken):
    - pc_write=0, if_id_write=0, id_ex_flush=1.
    - ex_mem_write and mem_wb_write stay 1.
  - **Normal**: all writes 1, all flushes 0, pc_src=0.
- MEM_WAIT:
  - The freeze holds while dmem_ready=0.
  - In the cycle dmem_ready=1, the access completes: normal/branch/load-use rules apply and the next state is RUN.
  - A wait counter (8 bits) increments on each MEM_WAIT cycle.
  - On the cycle the counter reaches MEM_TIMEOUT without ready: set mem_error and go to HALT.
- HALT: all write enables 0, all flushes 0, dmem_req=0. Only reset exits HALT.
- Counters:
  - stall_cycles increments on every non-reset cycle with pc_write=0, including HALT.
  - flush_count increments on each taken-branch cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational (Mealy) from the current state and inputs. They take effect at the next clock edge.
- State, wait counter, mem_error and performance counters are registered.
- A zero-wait memory (ready in the same cycle as the request) causes no stall cycle.
- A memory op with ready after N cycles causes N freeze cycles.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 3 flushed instructions.
- Reset while reset=1:
  - Outputs: all write enables 0, all flushes 1, pc_src=0, dmem_req=0.
  - Registered next values: state RUN, wait counter 0, mem_error 0, stall_cycles 0, flush_count 0.
- Reset asserted mid-MEM_WAIT or in HALT takes effect at the next edge, identically.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, HALT),
  - REG_ADDR_W=5,
  - the default CNT_W.
- Sub-module sat_counter (parameter W; inputs clock, reset, inc; output count) is instantiated twice, for stall_cycles and flush_count.

## Test plan
- **Load-use:** idex_mem_read=1, idex_rd=5, id_rs1=5, id_uses_rs1=1 → 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1; the next cycle is normal.
- **x0 exemption:** idex_rd=0 with matching rs1 → no stall. A mismatch (rd=6) also gives no stall.
- **Taken branch:** exmem_branch=1, exmem_zero=1 coinciding with a load-use match → pc_src=1; IF/ID, ID/EX, EX/MEM flushed; no stall; flush_count=1.
- **Memory wait:** exmem_mem_read=1, dmem_ready low for 3 cycles then high → 3 freeze cycles with mem_wb_flush=1; state RUN after ready; stall_cycles=3. With dmem_ready=1 immediately → 0 stalls.
- **Timeout:** MEM_TIMEOUT=4, dmem_ready stuck 0 → HALT after 4 wait cycles; mem_error=1; dmem_req=0; stall_cycles keeps incrementing. Then reset → RUN, mem_error=0, counters 0.
- **Saturation:** CNT_W=4, 20 stall cycles → stall_cycles=15 and holds at 15.
